// File: rtl/ntsc_vram_arb.sv
// rtl/ntsc_vram_arb.sv - text-mode VRAM/font fetch arbiter and pixel serializer for an NTSC encoder
module ntsc_vram_arb #(
  parameter int         C_COLS = 80,
  parameter int         C_ROWS = 30,
  parameter int         C_HTOT = 780,
  parameter int         C_VTOT = 263,
  parameter logic [5:0] C_FG_Y = 6'd48,
  parameter logic [5:0] C_BG_Y = 6'd0,
  parameter logic [2:0] C_CPH  = 3'd0
) (
  input  logic        CK_i,
  input  logic        ARST_i,
  input  logic        PX_CK_EE_i,
  input  logic [9:0]  HCTRs_i,
  input  logic [9:0]  VCTRs_i,
  input  logic        HREQ_i,
  input  logic        HWE_i,
  input  logic [11:0] HADRs_i,
  input  logic [7:0]  HWDs_i,
  output logic        HACK_o,
  output logic [7:0]  HRDs_o,
  output logic [11:0] VA_o,
  output logic        VWE_o,
  output logic [7:0]  VWDs_o,
  input  logic [7:0]  VRDs_i,
  output logic [9:0]  FA_o,
  input  logic [4:0]  FDs_i,
  output logic [5:0]  YYs_o,
  output logic [2:0]  CPHs_o
);

  localparam int CELLS = C_COLS * C_ROWS;

  typedef enum logic [2:0] {S_IDLE, S_DRD, S_DFONT, S_HACC, S_HDONE} state_t;
  state_t state, state_nx;

  logic        active, req_col, req_nl, host_ok;
  logic [9:0]  nline, rq_line;
  logic [6:0]  rq_col;
  logic [11:0] rq_addr;
  logic        d_pend, inv, font_ld;
  logic [11:0] d_addr, f_addr;
  logic [2:0]  d_frow, f_frow;
  logic [7:0]  next_pat, cur_pat, pix;
  logic        fg;

  assign active  = (HCTRs_i < 10'd640) && (VCTRs_i < 10'd240);
  assign nline   = (VCTRs_i == 10'(C_VTOT - 1)) ? 10'd0 : VCTRs_i + 10'd1;
  assign req_col = PX_CK_EE_i && (VCTRs_i < 10'd240) && (HCTRs_i[2:0] == 3'd3) && (HCTRs_i < 10'd632);
  assign req_nl  = PX_CK_EE_i && (HCTRs_i == 10'(C_HTOT - 5)) && (nline < 10'd240);
  assign rq_line = req_nl ? nline : VCTRs_i;
  assign rq_col  = req_nl ? 7'd0 : HCTRs_i[9:3] + 7'd1;
  assign rq_addr = {5'd0, rq_line[9:3]} * 12'(C_COLS) + {5'd0, rq_col};
  assign host_ok = HADRs_i < 12'(CELLS);
  assign CPHs_o  = C_CPH;

  // A newer display request simply replaces an unserved one
  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      state   <= S_IDLE;
      d_pend  <= 1'b0;
      d_addr  <= '0;
      d_frow  <= '0;
      f_addr  <= '0;
      f_frow  <= '0;
      inv     <= 1'b0;
      font_ld <= 1'b0;
      HRDs_o  <= '0;
    end else begin
      state   <= state_nx;
      font_ld <= (state == S_DFONT);
      if (req_col || req_nl) begin
        d_pend <= 1'b1;
        d_addr <= rq_addr;
        d_frow <= rq_line[2:0];
      end else if (state == S_IDLE && d_pend) begin
        d_pend <= 1'b0;
      end
      if (state == S_IDLE && d_pend) begin
        f_addr <= d_addr;
        f_frow <= d_frow;
      end
      if (state == S_DFONT)
        inv <= VRDs_i[7];
      if (state == S_HDONE && !HWE_i)
        HRDs_o <= host_ok ? VRDs_i : 8'd0;
    end
  end

  always_comb begin
    state_nx = state;
    VA_o     = '0;
    VWE_o    = 1'b0;
    VWDs_o   = '0;
    FA_o     = '0;
    HACK_o   = 1'b0;
    case (state)
      S_IDLE: begin
        if (d_pend)      state_nx = S_DRD;
        else if (HREQ_i) state_nx = S_HACC;
      end
      S_DRD: begin
        VA_o     = f_addr;
        state_nx = S_DFONT;
      end
      S_DFONT: begin
        FA_o     = {VRDs_i[6:0], f_frow};
        state_nx = S_IDLE;
      end
      S_HACC: begin
        VA_o     = HADRs_i;
        VWE_o    = HWE_i && host_ok;
        VWDs_o   = HWDs_i;
        state_nx = S_HDONE;
      end
      S_HDONE: begin
        HACK_o   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Bits 5..7 carry the inverse flag so gap columns and font row 7 light up in inverse cells
  assign pix = (HCTRs_i[2:0] == 3'd0) ? next_pat : cur_pat;
  assign fg  = active && ((VCTRs_i[2:0] == 3'd7) ? pix[7] : pix[HCTRs_i[2:0]]);

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      next_pat <= '0;
      cur_pat  <= '0;
      YYs_o    <= C_BG_Y;
    end else begin
      if (font_ld)
        next_pat <= {{3{inv}}, FDs_i ^ {5{inv}}};
      if (PX_CK_EE_i) begin
        if (HCTRs_i[2:0] == 3'd0)
          cur_pat <= next_pat;
        YYs_o <= fg ? C_FG_Y : C_BG_Y;
      end
    end
  end

endmodule
